// File: rtl/aes_ctr_stream.sv
// AES-128 counter-mode stream encryptor.
// An iterative AES-128 core generates one keystream block per counter value.
// Each plaintext block is XORed with the buffered keystream and pushed into a
// first-word-fall-through output FIFO that drains independently of the FSM.

module aes128_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic [127:0] plain_text_i,
    output logic         ready_o,
    output logic         done_o,
    output logic [127:0] cipher_text_o
);

    // Forward S-box, byte x lives at bits [2047-8x -: 8]
    localparam logic [2047:0] SBOX = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

    logic [127:0] state_q;
    logic [127:0] rkey_q;
    logic [3:0]   round_q;
    logic [7:0]   rcon_q;
    logic         running_q;
    logic         done_q;
    logic [127:0] next_key;
    logic [127:0] round_out;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes followed by ShiftRows; byte index 4*col+row, byte 0 at [127:120]
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127 - 8 * (4 * c + w) -: 8] = sbox(s[127 - 8 * (4 * ((c + w) % 4) + w) -: 8]);
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[127 - 32 * c -: 32] = mix_col(s[127 - 32 * c -: 32]);
        end
        return r;
    endfunction

    // One step of the AES-128 key schedule
    function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rcon);
        logic [31:0] w0, w1, w2, w3, rot, tmp;
        w0  = k[127:96];
        w1  = k[95:64];
        w2  = k[63:32];
        w3  = k[31:0];
        rot = {w3[23:0], w3[31:24]};
        tmp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rcon, 24'h0};
        w0  = w0 ^ tmp;
        w1  = w1 ^ w0;
        w2  = w2 ^ w1;
        w3  = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Round function for the current round; the final round skips MixColumns
    always_comb begin
        logic [127:0] t;
        next_key = expand_key(rkey_q, rcon_q);
        t = sub_shift(state_q);
        if (round_q != 4'd10) begin
            t = mix_columns(t);
        end
        round_out = t ^ next_key;
    end

    // Iterate one round per cycle; done pulses when the ciphertext is in state_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= '0;
            rkey_q    <= '0;
            round_q   <= '0;
            rcon_q    <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i && !running_q) begin
                state_q   <= plain_text_i ^ key_i;
                rkey_q    <= key_i;
                round_q   <= 4'd1;
                rcon_q    <= 8'h01;
                running_q <= 1'b1;
            end else if (running_q) begin
                state_q <= round_out;
                rkey_q  <= next_key;
                rcon_q  <= xtime(rcon_q);
                round_q <= round_q + 4'd1;
                if (round_q == 4'd10) begin
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                end
            end
        end
    end

    assign ready_o       = !running_q;
    assign done_o        = done_q;
    assign cipher_text_o = state_q;

endmodule

module aes_ctr_stream #(
    parameter int CTR_WIDTH = 32,
    parameter int OUT_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic [127:0] iv_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    input  logic [127:0] s_data_i,
    input  logic         s_last_i,
    output logic         m_valid_o,
    input  logic         m_ready_i,
    output logic [127:0] m_data_o,
    output logic         m_last_o,
    output logic         busy_o,
    output logic         wrap_o,
    output logic [31:0]  blk_cnt_o
);

    localparam int AW = $clog2(OUT_DEPTH);
    // Ones over the incrementing counter field, zeros over the fixed upper bits
    localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_WIDTH);

    typedef enum logic [1:0] {IDLE, GEN, WAIT_DATA} state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q;
    logic [127:0] ctr_q;
    logic [127:0] ks_q;
    logic         gen_issued_q;
    logic [31:0]  blk_cnt_q;
    logic         wrap_q;

    logic         core_start;
    logic         core_ready;
    logic         core_done;
    logic [127:0] core_ct;

    logic         start_acc;
    logic         xfer;
    logic         pop;
    logic [127:0] ctr_next;
    logic         ctr_wraps;

    logic [128:0] fifo_mem [OUT_DEPTH];
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic         fifo_full, fifo_empty;
    logic [128:0] head;

    aes128_core u_core (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (core_start),
        .key_i         (key_q),
        .plain_text_i  (ctr_q),
        .ready_o       (core_ready),
        .done_o        (core_done),
        .cipher_text_o (core_ct)
    );

    assign start_acc = (state_q == IDLE) && start_i;
    assign xfer      = s_valid_i && s_ready_o;
    assign pop       = m_valid_o && m_ready_i;
    assign ctr_next  = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);
    assign ctr_wraps = (ctr_q & CTR_MASK) == CTR_MASK;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start_i) state_d = GEN;
            GEN:       if (core_done) state_d = WAIT_DATA;
            WAIT_DATA: if (xfer) state_d = s_last_i ? IDLE : GEN;
            default:   state_d = IDLE;
        endcase
    end

    // FSM outputs: core kick once per block, input ready only with a keystream buffered
    always_comb begin
        s_ready_o  = 1'b0;
        busy_o     = 1'b0;
        core_start = 1'b0;
        case (state_q)
            GEN: begin
                busy_o     = 1'b1;
                core_start = !gen_issued_q && core_ready;
            end
            WAIT_DATA: begin
                busy_o    = 1'b1;
                s_ready_o = !fifo_full;
            end
            default: ;
        endcase
    end

    // Key, counter and keystream buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q        <= '0;
            ctr_q        <= '0;
            ks_q         <= '0;
            gen_issued_q <= 1'b0;
        end else begin
            if (start_acc) begin
                key_q <= key_i;
                ctr_q <= iv_i;
            end else if (xfer) begin
                ctr_q <= ctr_next;
            end
            if (core_start) begin
                gen_issued_q <= 1'b1;
            end else if ((state_q == GEN) && core_done) begin
                gen_issued_q <= 1'b0;
                ks_q         <= core_ct;
            end
        end
    end

    // Per-message block count (saturating) and sticky counter-wrap flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q <= '0;
            wrap_q    <= 1'b0;
        end else if (start_acc) begin
            blk_cnt_q <= '0;
            wrap_q    <= 1'b0;
        end else if (xfer) begin
            if (blk_cnt_q != 32'hffff_ffff) begin
                blk_cnt_q <= blk_cnt_q + 32'd1;
            end
            if (ctr_wraps) begin
                wrap_q <= 1'b1;
            end
        end
    end

    // FIFO storage; entries are never read while stale so they need no reset
    always_ff @(posedge clk) begin
        if (xfer) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= {s_data_i ^ ks_q, s_last_i};
        end
    end

    // FIFO pointers with a wrap bit to tell full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (xfer) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign fifo_empty = wr_ptr_q == rd_ptr_q;
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head       = fifo_mem[rd_ptr_q[AW-1:0]];

    assign m_valid_o = !fifo_empty;
    assign m_data_o  = m_valid_o ? head[128:1] : '0;
    assign m_last_o  = m_valid_o && head[0];
    assign wrap_o    = wrap_q;
    assign blk_cnt_o = blk_cnt_q;

endmodule

// File: tb/tb_aes_ctr_stream.sv
// Directed bench for aes_ctr_stream using FIPS-197 and SP800-38A CTR vectors.
// A second instance with an 8-bit counter field covers counter wrap-around.

module tb_aes_ctr_stream;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] IV1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV2  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] IV3  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdffff;
    localparam logic [127:0] PT1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] PT2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] PT3  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] PT4  = 128'hf69f2445df4f9b17ad2b417be66c3710;
    localparam logic [127:0] CT1  = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] CT2  = 128'h9806f66b7970fdff8617187bb9fffdff;
    localparam logic [127:0] CT3  = 128'h5ae4df3edbd5d35e5b4f09020db03eab;
    localparam logic [127:0] CT4  = 128'h1e031dda2fbe03d1792170a0f3009cee;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic [127:0] key_i;
    logic [127:0] iv_i;
    logic         s_valid_i;
    logic [127:0] s_data_i;
    logic         s_last_i;
    logic         m_ready_i;

    logic         s_ready_o, m_valid_o, m_last_o, busy_o, wrap_o;
    logic [127:0] m_data_o;
    logic [31:0]  blk_cnt_o;
    logic         s_ready_b, m_valid_b, m_last_b, busy_b, wrap_b;
    logic [127:0] m_data_b;
    logic [31:0]  blk_cnt_b;

    int assert_count = 0;
    int fail_count   = 0;
    int last_wait    = 0;

    always #5 clk = ~clk;

    aes_ctr_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .key_i     (key_i),
        .iv_i      (iv_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .s_data_i  (s_data_i),
        .s_last_i  (s_last_i),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_data_o  (m_data_o),
        .m_last_o  (m_last_o),
        .busy_o    (busy_o),
        .wrap_o    (wrap_o),
        .blk_cnt_o (blk_cnt_o)
    );

    aes_ctr_stream #(.CTR_WIDTH(8), .OUT_DEPTH(4)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .key_i     (key_i),
        .iv_i      (iv_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_b),
        .s_data_i  (s_data_i),
        .s_last_i  (s_last_i),
        .m_valid_o (m_valid_b),
        .m_ready_i (m_ready_i),
        .m_data_o  (m_data_b),
        .m_last_o  (m_last_b),
        .busy_o    (busy_b),
        .wrap_o    (wrap_b),
        .blk_cnt_o (blk_cnt_b)
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic startMsg(input logic [127:0] key, input logic [127:0] iv);
        key_i   = key;
        iv_i    = iv;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    // Offer one plaintext block and hold it until the DUT takes it
    task automatic applyStimulus(input logic [127:0] data, input logic last, input string tag);
        int waited;
        waited    = 0;
        s_valid_i = 1'b1;
        s_data_i  = data;
        s_last_i  = last;
        while (!s_ready_o && waited < 200) begin
            step();
            waited++;
        end
        if (!s_ready_o) begin
            checkOutput({tag, " ready timeout"}, 128'd0, 128'd1);
        end else begin
            step();
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        last_wait = waited;
    endtask

    // Wait for an output block, check it, then pop it
    task automatic popOutput(input logic sel_b, input logic check_data,
                             input logic [127:0] exp_data, input logic exp_last,
                             input string tag);
        int waited;
        waited = 0;
        while (!(sel_b ? m_valid_b : m_valid_o) && waited < 200) begin
            step();
            waited++;
        end
        checkOutput({tag, " valid"}, 128'(sel_b ? m_valid_b : m_valid_o), 128'd1);
        if (check_data) begin
            checkOutput({tag, " data"}, sel_b ? m_data_b : m_data_o, exp_data);
        end
        checkOutput({tag, " last"}, 128'(sel_b ? m_last_b : m_last_o), 128'(exp_last));
        m_ready_i = 1'b1;
        step();
        m_ready_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        rst_n     = 1'b0;
        start_i   = 1'b0;
        key_i     = '0;
        iv_i      = '0;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        s_last_i  = 1'b0;
        m_ready_i = 1'b0;
        step();
        step();

        // Reset values
        checkOutput("reset m_valid", 128'(m_valid_o), 128'd0);
        checkOutput("reset s_ready", 128'(s_ready_o), 128'd0);
        checkOutput("reset busy", 128'(busy_o), 128'd0);
        checkOutput("reset wrap", 128'(wrap_o), 128'd0);
        checkOutput("reset blk_cnt", 128'(blk_cnt_o), 128'd0);
        checkOutput("reset m_data", m_data_o, 128'd0);
        checkOutput("reset m_last", 128'(m_last_o), 128'd0);
        rst_n = 1'b1;
        step();

        // FIPS-197 single block, zero plaintext
        startMsg(KEY1, IV1);
        checkOutput("t1 busy after start", 128'(busy_o), 128'd1);
        checkOutput("t1 s_ready in GEN", 128'(s_ready_o), 128'd0);
        applyStimulus(128'd0, 1'b1, "t1 blk0");
        checkOutput("t1 latency >= 11", 128'(last_wait >= 11), 128'd1);
        checkOutput("t1 busy after last", 128'(busy_o), 128'd0);
        checkOutput("t1 m_valid after push", 128'(m_valid_o), 128'd1);
        checkOutput("t1 blk_cnt", 128'(blk_cnt_o), 128'd1);
        popOutput(1'b0, 1'b1, CT0, 1'b1, "t1 out0");
        checkOutput("t1 drained", 128'(m_valid_o), 128'd0);

        // SP800-38A two blocks, with an ignored start pulse in WAIT_DATA
        startMsg(KEY2, IV2);
        applyStimulus(PT1, 1'b0, "t2 blk0");
        checkOutput("t2 busy mid msg", 128'(busy_o), 128'd1);
        checkOutput("t2 blk_cnt 1", 128'(blk_cnt_o), 128'd1);
        waited = 0;
        while (!s_ready_o && waited < 200) begin
            step();
            waited++;
        end
        checkOutput("t2 reached WAIT_DATA", 128'(s_ready_o), 128'd1);
        startMsg(KEY1, IV1);
        checkOutput("t2 start ignored blk_cnt", 128'(blk_cnt_o), 128'd1);
        checkOutput("t2 start ignored s_ready", 128'(s_ready_o), 128'd1);
        applyStimulus(PT2, 1'b1, "t2 blk1");
        checkOutput("t2 blk_cnt 2", 128'(blk_cnt_o), 128'd2);
        checkOutput("t2 no wrap", 128'(wrap_o), 128'd0);
        popOutput(1'b0, 1'b1, CT1, 1'b0, "t2 out0");
        popOutput(1'b0, 1'b1, CT2, 1'b1, "t2 out1");

        // 8-bit counter field wraps ff->00; keystream must match counter ..fdff00
        startMsg(KEY2, IV3);
        applyStimulus(PT1, 1'b0, "t3 blk0");
        checkOutput("t3 wrap 8-bit", 128'(wrap_b), 128'd1);
        checkOutput("t3 no wrap 32-bit", 128'(wrap_o), 128'd0);
        applyStimulus(PT2, 1'b1, "t3 blk1");
        checkOutput("t3 blk_cnt 8-bit", 128'(blk_cnt_b), 128'd2);
        popOutput(1'b1, 1'b0, 128'd0, 1'b0, "t3 out0");
        popOutput(1'b1, 1'b1, CT2, 1'b1, "t3 out1");
        checkOutput("t3 wrap sticky", 128'(wrap_b), 128'd1);

        // Back-pressure: six blocks into a four-entry FIFO
        startMsg(KEY2, IV2);
        checkOutput("t4 wrap cleared", 128'(wrap_b), 128'd0);
        applyStimulus(PT1, 1'b0, "t4 blk0");
        applyStimulus(PT2, 1'b0, "t4 blk1");
        applyStimulus(PT3, 1'b0, "t4 blk2");
        applyStimulus(PT4, 1'b0, "t4 blk3");
        for (int i = 0; i < 20; i++) begin
            step();
        end
        checkOutput("t4 s_ready low when full", 128'(s_ready_o), 128'd0);
        checkOutput("t4 blk_cnt 4", 128'(blk_cnt_o), 128'd4);
        checkOutput("t4 busy", 128'(busy_o), 128'd1);
        checkOutput("t4 head held", m_data_o, CT1);
        fork
            begin
                applyStimulus(128'h0123456789abcdef0123456789abcdef, 1'b0, "t4 blk4");
                applyStimulus(128'hfedcba9876543210fedcba9876543210, 1'b1, "t4 blk5");
            end
            begin
                popOutput(1'b0, 1'b1, CT1, 1'b0, "t4 out0");
                popOutput(1'b0, 1'b1, CT2, 1'b0, "t4 out1");
                popOutput(1'b0, 1'b1, CT3, 1'b0, "t4 out2");
                popOutput(1'b0, 1'b1, CT4, 1'b0, "t4 out3");
                popOutput(1'b0, 1'b0, 128'd0, 1'b0, "t4 out4");
                popOutput(1'b0, 1'b0, 128'd0, 1'b1, "t4 out5");
            end
        join
        checkOutput("t4 drained", 128'(m_valid_o), 128'd0);
        checkOutput("t4 blk_cnt 6", 128'(blk_cnt_o), 128'd6);
        checkOutput("t4 idle", 128'(busy_o), 128'd0);

        // Reset while generating block 2 discards everything
        startMsg(KEY1, IV1);
        applyStimulus(128'd0, 1'b0, "t5 blk0");
        step();
        step();
        step();
        checkOutput("t5 pre-reset valid", 128'(m_valid_o), 128'd1);
        rst_n = 1'b0;
        step();
        checkOutput("t5 rst m_valid", 128'(m_valid_o), 128'd0);
        checkOutput("t5 rst m_data", m_data_o, 128'd0);
        checkOutput("t5 rst busy", 128'(busy_o), 128'd0);
        checkOutput("t5 rst blk_cnt", 128'(blk_cnt_o), 128'd0);
        checkOutput("t5 rst s_ready", 128'(s_ready_o), 128'd0);
        rst_n = 1'b1;
        step();
        step();
        startMsg(KEY1, IV1);
        applyStimulus(128'd0, 1'b1, "t5 blk0 again");
        checkOutput("t5 blk_cnt", 128'(blk_cnt_o), 128'd1);
        popOutput(1'b0, 1'b1, CT0, 1'b1, "t5 out0");

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/aes_ctr_stream.md
AES_CTR_STREAM -- requirements
Module: aes_ctr_stream

Interface
REQ-001 Parameter CTR_WIDTH, default 32, number of low IV bits that increment per block (legal 8..128).
REQ-002 Parameter OUT_DEPTH, default 4, output FIFO depth in 128-bit entries (power of two, >=2).
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  one-cycle pulse; loads key_i/iv_i and begins a message.
REQ-006 key_i  input  128  AES-128 key, sampled only on an accepted start.
REQ-007 iv_i  input  128  initial counter block, sampled only on an accepted start.
REQ-008 s_valid_i / s_ready_o / s_data_i[127:0] / s_last_i  input/output/input/input  plaintext stream; s_last_i marks the final block.
REQ-009 m_valid_o / m_ready_i / m_data_o[127:0] / m_last_o  output/input/output/output  ciphertext stream.
REQ-010 busy_o  output  1  high from accepted start until the last block is written into the FIFO.
REQ-011 wrap_o  output  1  sticky; set when the counter field wraps within a message.
REQ-012 blk_cnt_o  output  32  blocks accepted since the last start, saturating at 2^32-1.

Function
REQ-013 Keystream SHALL be produced by one instance of the existing aes128_core (start_i/ready_o/done_o handshake); no second AES datapath.
REQ-014 FSM states IDLE, GEN, WAIT_DATA; a registered one-entry keystream buffer holds the current keystream block.
REQ-015 IDLE: start_i accepted -> latch key and counter=iv_i, clear blk_cnt_o and wrap_o, go to GEN; start_i ignored in GEN/WAIT_DATA.
REQ-016 GEN: pulse core start once when core ready_o is high; on core done_o capture cipher_text_o into the keystream buffer, go to WAIT_DATA.
REQ-017 WAIT_DATA: s_ready_o = 1 iff FIFO not full; s_ready_o = 0 in all other states.
REQ-018 On s_valid_i & s_ready_o: push {s_data_i XOR keystream, s_last_i} into FIFO same cycle; blk_cnt_o += 1; counter increments.
REQ-019 After a transfer: s_last_i=1 -> IDLE, busy_o low next cycle; else -> GEN.
REQ-020 Counter increment: low CTR_WIDTH bits +1 modulo 2^CTR_WIDTH, upper 128-CTR_WIDTH bits unchanged; all-ones -> zero sets wrap_o.
REQ-021 Block ordering: FIFO byte 0 = bits [127:120]; XOR is bitwise, no byte reordering.
REQ-022 FIFO: first-word-fall-through; m_valid_o = not empty; pop on m_valid_o & m_ready_i; simultaneous push and pop when full is not possible (s_ready_o low when full); simultaneous push and pop otherwise both take effect.
REQ-023 m_data_o/m_last_o SHALL hold stable while m_valid_o=1 and m_ready_i=0.
REQ-024 FIFO output continues draining in IDLE; a new start while FIFO non-empty is accepted and appends behind older data.
REQ-025 Latency: first s_ready_o no earlier than core latency +1 cycle after start; output valid one cycle after push.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, FIFO empty, m_valid_o=0, s_ready_o=0, busy_o=0, wrap_o=0, blk_cnt_o=0, m_data_o=0, m_last_o=0, counter/key=0.
REQ-027 Reset mid-message discards keystream and FIFO contents; core is reset by the same rst_n.

Verification
REQ-028 key 000102..0f, iv 00112233445566778899aabbccddeeff, plaintext 0, last=1 -> m_data_o 69c4e0d86a7b0430d8cdb78070b4c55a, m_last_o=1, blk_cnt_o=1.
REQ-029 key 2b7e151628aed2a6abf7158809cf4f3c, iv f0f1..feff, pt 6bc1bee22e409f96e93d7e117393172a then ae2d8a571e03ac9c9eb76fac45af8e51 -> 874d6191b620e3261bef6864990db6ce then 9806f66b7970fdff8617187bb9fffdff.
REQ-030 CTR_WIDTH=8, iv low byte ff, 2 blocks -> second block uses low byte 00, upper bits unchanged, wrap_o=1.
REQ-031 m_ready_i=0 for 6 blocks, OUT_DEPTH=4 -> s_ready_o low after 4th push, no data lost; release -> 6 blocks out in order, last flagged.
REQ-032 rst_n asserted during GEN of block 2 -> all outputs at reset values next edge; new start after release yields REQ-028 result.
REQ-033 start_i pulsed during WAIT_DATA -> ignored; key, counter and blk_cnt_o unchanged.
